// File: rtl/cmp_pkg.sv
// Shared definitions for the chunked branch-condition comparator:
// condition codes, per-stage state bundle and small decode helpers.
package cmp_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_EQ  = 4'd0;
  localparam logic [OP_W-1:0] OP_NE  = 4'd1;
  localparam logic [OP_W-1:0] OP_LT  = 4'd2;
  localparam logic [OP_W-1:0] OP_GE  = 4'd3;
  localparam logic [OP_W-1:0] OP_LTU = 4'd4;
  localparam logic [OP_W-1:0] OP_GEU = 4'd5;
  localparam logic [OP_W-1:0] OP_LTZ = 4'd6;
  localparam logic [OP_W-1:0] OP_GTZ = 4'd7;
  localparam logic [OP_W-1:0] OP_LEZ = 4'd8;
  localparam logic [OP_W-1:0] OP_GEZ = 4'd9;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            decided;
    logic            lt;
  } stage_t;

  function automatic int nstage(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic logic op_is_zero(input logic [OP_W-1:0] op);
    return op inside {OP_LTZ, OP_GTZ, OP_LEZ, OP_GEZ};
  endfunction

  // Everything outside this set, including the reserved codes, compares signed.
  function automatic logic op_is_unsigned(input logic [OP_W-1:0] op);
    return op inside {OP_EQ, OP_NE, OP_LTU, OP_GEU};
  endfunction

  function automatic logic cond_taken(input logic [OP_W-1:0] op,
                                      input logic            eq,
                                      input logic            lt);
    logic gt;
    logic taken;
    gt = !eq && !lt;
    case (op)
      OP_EQ:   taken = eq;
      OP_NE:   taken = !eq;
      OP_LT:   taken = lt;
      OP_GE:   taken = !lt;
      OP_LTU:  taken = lt;
      OP_GEU:  taken = !lt;
      OP_LTZ:  taken = lt;
      OP_GTZ:  taken = gt;
      OP_LEZ:  taken = lt || eq;
      OP_GEZ:  taken = !lt;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// One comparator slice: folds one operand chunk into the running
// decided/lt state; the first differing chunk (MSB side) wins.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic             prev_decided,
  input  logic             prev_lt,
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  output logic             next_decided,
  output logic             next_lt
);

  always_comb begin
    next_decided = prev_decided;
    next_lt      = prev_lt;
    if (!prev_decided && (a_chunk != b_chunk)) begin
      next_decided = 1'b1;
      next_lt      = (a_chunk < b_chunk);
    end
  end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch-condition resolver: one CHUNK per stage, MSB chunk first,
// with valid/ready handshake, in-order tag, stall and flush.
module branch_cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_eq,
  output logic             out_lt,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NSTAGE = nstage(WIDTH, CHUNK);
  localparam int NREG   = (NSTAGE > 1) ? NSTAGE - 1 : 1;
  localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

  if (((WIDTH % CHUNK) != 0) || (NSTAGE < 1)) begin : g_bad_chunk
    $error("branch_cmp_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             advance;
  logic [NSTAGE-1:0] vld_p;

  stage_t           st_p  [NREG];
  logic [TAG_W-1:0] tag_p [NREG];
  logic [WIDTH-1:0] a_p   [NREG];
  logic [WIDTH-1:0] b_p   [NREG];

  stage_t           sel_st  [NSTAGE];
  logic [TAG_W-1:0] sel_tag [NSTAGE];
  logic [WIDTH-1:0] sel_a   [NSTAGE];
  logic [WIDTH-1:0] sel_b   [NSTAGE];
  logic             nxt_dec [NSTAGE];
  logic             nxt_lt  [NSTAGE];

  logic [WIDTH-1:0] bias_mask;
  logic [WIDTH-1:0] b_src;
  logic             fin_eq;
  logic             fin_lt;
  logic             fin_taken;

  assign out_valid = vld_p[NSTAGE-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !flush;

  // Stage 0 input: flipping the sign bit turns a signed compare into unsigned
  always_comb begin
    bias_mask = op_is_unsigned(in_op) ? '0 : SIGN_BIT;
    b_src     = op_is_zero(in_op) ? '0 : in_b;
  end

  always_comb begin
    sel_a[0]   = in_a ^ bias_mask;
    sel_b[0]   = b_src ^ bias_mask;
    sel_st[0]  = '{op: in_op, decided: 1'b0, lt: 1'b0};
    sel_tag[0] = in_tag;
    for (int k = 1; k < NSTAGE; k++) begin
      sel_a[k]   = a_p[k-1];
      sel_b[k]   = b_p[k-1];
      sel_st[k]  = st_p[k-1];
      sel_tag[k] = tag_p[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_chunk
    cmp_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .prev_decided(sel_st[k].decided),
      .prev_lt     (sel_st[k].lt),
      .a_chunk     (sel_a[k][WIDTH-1 -: CHUNK]),
      .b_chunk     (sel_b[k][WIDTH-1 -: CHUNK]),
      .next_decided(nxt_dec[k]),
      .next_lt     (nxt_lt[k])
    );
  end

  // Final stage: resolve the condition before it lands in the output register
  assign fin_eq    = !nxt_dec[NSTAGE-1];
  assign fin_lt    = nxt_lt[NSTAGE-1];
  assign fin_taken = cond_taken(sel_st[NSTAGE-1].op, fin_eq, fin_lt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p     <= '0;
      out_taken <= 1'b0;
      out_eq    <= 1'b0;
      out_lt    <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else if (advance) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < NSTAGE; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      out_taken <= fin_taken;
      out_eq    <= fin_eq;
      out_lt    <= fin_lt;
      out_tag   <= sel_tag[NSTAGE-1];
    end
  end

  // Stage k -> k+1: the resolved chunk is shifted out so the next one sits at the top
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < NSTAGE - 1; k++) begin
        st_p[k]  <= '{op: sel_st[k].op, decided: nxt_dec[k], lt: nxt_lt[k]};
        tag_p[k] <= sel_tag[k];
        a_p[k]   <= sel_a[k] << CHUNK;
        b_p[k]   <= sel_b[k] << CHUNK;
      end
    end
  end

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Directed bench for branch_cmp_pipe: default 32/8 instance plus 32/32 and
// 64/16 instances sharing the control inputs.
module tb_branch_cmp_pipe;
  import cmp_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic [63:0] a64, b64;
  logic [3:0]  in_op;
  logic [4:0]  in_tag;

  logic       in_ready0, out_valid0, out_taken0, out_eq0, out_lt0;
  logic [4:0] out_tag0;
  logic       in_ready1, out_valid1, out_taken1, out_eq1, out_lt1;
  logic [4:0] out_tag1;
  logic       in_ready2, out_valid2, out_taken2, out_eq2, out_lt2;
  logic [4:0] out_tag2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_cmp_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .out_taken(out_taken0),
    .out_eq(out_eq0), .out_lt(out_lt0), .out_tag(out_tag0));

  branch_cmp_pipe #(.WIDTH(32), .CHUNK(32), .TAG_W(5)) dut_c32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .out_taken(out_taken1),
    .out_eq(out_eq1), .out_lt(out_lt1), .out_tag(out_tag1));

  branch_cmp_pipe #(.WIDTH(64), .CHUNK(16), .TAG_W(5)) dut_w64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(a64), .in_b(b64), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready), .out_taken(out_taken2),
    .out_eq(out_eq2), .out_lt(out_lt2), .out_tag(out_tag2));

  function automatic logic vsel(input int w);
    case (w)
      0:       return out_valid0;
      1:       return out_valid1;
      default: return out_valid2;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one op for one edge, then count edges until the chosen instance shows out_valid.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, input int which, output int lat);
    in_op = op; in_a = a[31:0]; in_b = b[31:0]; a64 = a; b64 = b; in_tag = tag;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!vsel(which) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; a64 = '0; b64 = '0; in_op = '0; in_tag = '0;
    @(posedge clk); #1;
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid0); end
    total++; if ({out_taken0, out_eq0, out_lt0} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {out_taken0, out_eq0, out_lt0}); end
    total++; if (out_tag0 !== 5'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", out_tag0); end
    reset = 1'b0;
    #1;
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready0); end
    total++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin bad++; $display("FAIL reset_valid_variants got=%b%b want=00", out_valid1, out_valid2); end
    idle(1);
  endtask

  task automatic test_basic;
    int lat;
    issue(OP_EQ, 64'd5, 64'd5, 5'd3, 0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL eq_latency got=%0d want=4", lat); end
    total++; if ({out_taken0, out_eq0, out_lt0} !== 3'b110) begin bad++; $display("FAIL eq_flags got=%b want=110", {out_taken0, out_eq0, out_lt0}); end
    total++; if (out_tag0 !== 5'd3) begin bad++; $display("FAIL eq_tag got=%0d want=3", out_tag0); end
    issue(OP_NE, 64'd5, 64'd5, 5'd3, 0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL ne_latency got=%0d want=4", lat); end
    total++; if ({out_taken0, out_eq0, out_lt0} !== 3'b010) begin bad++; $display("FAIL ne_flags got=%b want=010", {out_taken0, out_eq0, out_lt0}); end
  endtask

  task automatic test_signed;
    int lat;
    issue(OP_LT, 64'hFFFF_FFFF, 64'h1, 5'd7, 0, lat);
    total++; if ({out_taken0, out_eq0, out_lt0} !== 3'b101) begin bad++; $display("FAIL lt_flags got=%b want=101", {out_taken0, out_eq0, out_lt0}); end
    issue(OP_LTU, 64'hFFFF_FFFF, 64'h1, 5'd8, 0, lat);
    total++; if ({out_taken0, out_eq0, out_lt0} !== 3'b000) begin bad++; $display("FAIL ltu_flags got=%b want=000", {out_taken0, out_eq0, out_lt0}); end
    issue(OP_GEU, 64'hFFFF_FFFF, 64'h1, 5'd9, 0, lat);
    total++; if ({out_taken0, out_lt0} !== 2'b10) begin bad++; $display("FAIL geu_flags got=%b want=10", {out_taken0, out_lt0}); end
    total++; if (out_tag0 !== 5'd9) begin bad++; $display("FAIL geu_tag got=%0d want=9", out_tag0); end
    issue(OP_GE, 64'h3, 64'hFFFF_FFFE, 5'd10, 0, lat);
    total++; if ({out_taken0, out_eq0, out_lt0} !== 3'b100) begin bad++; $display("FAIL ge_flags got=%b want=100", {out_taken0, out_eq0, out_lt0}); end
  endtask

  task automatic test_zero;
    int lat;
    issue(OP_LTZ, 64'h8000_0000, 64'h1234, 5'd1, 0, lat);
    total++; if ({out_taken0, out_lt0} !== 2'b11) begin bad++; $display("FAIL ltz_flags got=%b want=11", {out_taken0, out_lt0}); end
    issue(OP_GEZ, 64'h8000_0000, 64'h1234, 5'd2, 0, lat);
    total++; if (out_taken0 !== 1'b0) begin bad++; $display("FAIL gez_taken got=%b want=0", out_taken0); end
    issue(OP_LEZ, 64'h0, 64'h1234, 5'd4, 0, lat);
    total++; if ({out_taken0, out_eq0, out_lt0} !== 3'b110) begin bad++; $display("FAIL lez_flags got=%b want=110", {out_taken0, out_eq0, out_lt0}); end
    issue(OP_GTZ, 64'h0, 64'h1234, 5'd5, 0, lat);
    total++; if ({out_taken0, out_eq0} !== 2'b01) begin bad++; $display("FAIL gtz_flags got=%b want=01", {out_taken0, out_eq0}); end
    issue(4'd12, 64'h0, 64'h0, 5'd6, 0, lat);
    total++; if ({out_taken0, out_eq0, out_lt0} !== 3'b010) begin bad++; $display("FAIL op12_flags got=%b want=010", {out_taken0, out_eq0, out_lt0}); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  bop [6];
    logic [31:0] ba  [6];
    logic [31:0] bb  [6];
    logic [2:0]  bexp[6];
    int idx, cyc, lowcnt;
    bop[0] = OP_EQ;  ba[0] = 32'd5;         bb[0] = 32'd5; bexp[0] = 3'b110;
    bop[1] = OP_NE;  ba[1] = 32'd5;         bb[1] = 32'd6; bexp[1] = 3'b101;
    bop[2] = OP_LT;  ba[2] = 32'hFFFF_FFFF; bb[2] = 32'd1; bexp[2] = 3'b101;
    bop[3] = OP_LTU; ba[3] = 32'hFFFF_FFFF; bb[3] = 32'd1; bexp[3] = 3'b000;
    bop[4] = OP_GEZ; ba[4] = 32'h8000_0000; bb[4] = 32'd9; bexp[4] = 3'b001;
    bop[5] = OP_LEZ; ba[5] = 32'h0;         bb[5] = 32'd9; bexp[5] = 3'b110;
    idx = 0; cyc = 0; lowcnt = 0;
    idle(2);
    fork
      begin : driver
        int w;
        for (int i = 0; i < 6; i++) begin
          in_op = bop[i]; in_a = ba[i]; in_b = bb[i]; in_tag = 5'(i); in_valid = 1'b1;
          w = 0;
          @(negedge clk);
          while (!in_ready0 && w < 40) begin
            @(negedge clk);
            w++;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin : ready_ctl
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin : monitor
        while (idx < 6 && cyc < 60) begin
          @(negedge clk);
          cyc++;
          total++;
          if (in_ready0 !== !(out_valid0 && !out_ready)) begin
            bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", cyc, in_ready0, !(out_valid0 && !out_ready));
          end
          if (!in_ready0) lowcnt++;
          if (out_valid0 && out_ready) begin
            total++; if (out_tag0 !== 5'(idx)) begin bad++; $display("FAIL b2b_tag got=%0d want=%0d", out_tag0, idx); end
            total++; if ({out_taken0, out_eq0, out_lt0} !== bexp[idx]) begin bad++; $display("FAIL b2b_flags idx=%0d got=%b want=%b", idx, {out_taken0, out_eq0, out_lt0}, bexp[idx]); end
            idx++;
          end
        end
      end
    join
    total++; if (idx !== 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", idx); end
    total++; if (lowcnt !== 3) begin bad++; $display("FAIL b2b_stall_cycles got=%0d want=3", lowcnt); end
    idle(1);
  endtask

  task automatic test_flush;
    int lat, seen;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      in_op = OP_EQ; in_a = 32'd1; in_b = 32'd1; in_tag = 5'(10 + i); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_tag = 5'd13; flush = 1'b1;
    @(negedge clk);
    total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready0); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid0); end
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_leak got=%0d want=0", seen); end
    issue(OP_EQ, 64'd7, 64'd7, 5'd14, 0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL flush_next_latency got=%0d want=4", lat); end
    total++; if (out_tag0 !== 5'd14) begin bad++; $display("FAIL flush_next_tag got=%0d want=14", out_tag0); end
  endtask

  task automatic test_reset_midflight;
    int lat, seen;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      in_op = OP_NE; in_a = 32'd1; in_b = 32'd2; in_tag = 5'(20 + i); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (out_valid0 !== 1'b1 || out_tag0 !== 5'd20) begin bad++; $display("FAIL pre_reset_out got=%b/%0d want=1/20", out_valid0, out_tag0); end
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%b want=0", out_valid0); end
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL async_reset_in_ready got=%b want=1", in_ready0); end
    total++; if (out_tag0 !== 5'd0 || out_taken0 !== 1'b0) begin bad++; $display("FAIL async_reset_outs got=%0d/%b want=0/0", out_tag0, out_taken0); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL reset_leak got=%0d want=0", seen); end
    issue(OP_EQ, 64'd9, 64'd9, 5'd24, 0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL post_reset_latency got=%0d want=4", lat); end
    total++; if (out_tag0 !== 5'd24 || out_taken0 !== 1'b1) begin bad++; $display("FAIL post_reset_out got=%0d/%b want=24/1", out_tag0, out_taken0); end
  endtask

  task automatic test_chunk32;
    int lat;
    idle(6);
    issue(OP_EQ, 64'd5, 64'd5, 5'd3, 1, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL c32_latency got=%0d want=1", lat); end
    total++; if ({out_taken1, out_eq1, out_lt1} !== 3'b110 || out_tag1 !== 5'd3) begin bad++; $display("FAIL c32_out got=%b/%0d want=110/3", {out_taken1, out_eq1, out_lt1}, out_tag1); end
    issue(OP_LT, 64'hFFFF_FFFF, 64'h1, 5'd4, 1, lat);
    total++; if ({out_taken1, out_lt1} !== 2'b11) begin bad++; $display("FAIL c32_lt got=%b want=11", {out_taken1, out_lt1}); end
  endtask

  task automatic test_w64;
    int lat;
    idle(6);
    issue(OP_EQ, 64'd5, 64'd5, 5'd3, 2, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL w64_latency got=%0d want=4", lat); end
    total++; if ({out_taken2, out_eq2, out_lt2} !== 3'b110 || out_tag2 !== 5'd3) begin bad++; $display("FAIL w64_out got=%b/%0d want=110/3", {out_taken2, out_eq2, out_lt2}, out_tag2); end
    issue(OP_LT, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd5, 2, lat);
    total++; if ({out_taken2, out_lt2} !== 2'b11) begin bad++; $display("FAIL w64_lt got=%b want=11", {out_taken2, out_lt2}); end
    issue(OP_LTU, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 5'd6, 2, lat);
    total++; if ({out_taken2, out_eq2, out_lt2} !== 3'b000) begin bad++; $display("FAIL w64_ltu got=%b want=000", {out_taken2, out_eq2, out_lt2}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_zero;
    test_back_to_back;
    test_flush;
    test_reset_midflight;
    test_chunk32;
    test_w64;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
